// File: rtl/stepper_pkg.sv
// rtl/stepper_pkg.sv - shared types and constants for the stepper controller
package stepper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVE   = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  typedef logic [2:0] phase_t;

  localparam phase_t FULL_STEP = 3'd2;
  localparam phase_t HALF_STEP = 3'd1;

  // Entry 0 is the least significant nibble; even entries are the full-step sequence.
  localparam logic [7:0][3:0] COIL_TABLE = {
    4'b1000, 4'b1001, 4'b0001, 4'b0101,
    4'b0100, 4'b0110, 4'b0010, 4'b1010
  };

endpackage

// File: rtl/step_prescaler.sv
// rtl/step_prescaler.sv - step-period counter, ticks once every period+1 enabled cycles
module step_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [DIV_W-1:0] period_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  assign tick_o = enable_i && (cnt_q == period_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stepper_ctrl.sv
// rtl/stepper_ctrl.sv - 4-coil stepper move controller; COIL_IDLE_OFF_EN de-energises coils at rest
module stepper_ctrl
  import stepper_pkg::*;
#(
  parameter int POS_W = 16,
  parameter int DIV_W = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic [POS_W-1:0] steps,
  input  logic             half_step,
  input  logic [DIV_W-1:0] div,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             step_tick,
  output logic [POS_W-1:0] position,
  output logic [3:0]       coil
);

`ifdef COIL_IDLE_OFF_EN
  localparam logic [3:0] COIL_RESET = 4'b0000;
`else
  localparam logic [3:0] COIL_RESET = COIL_TABLE[0];
`endif

  state_e           state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [POS_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             half_q, half_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       coil_q, coil_d;
  logic             presc_tick;
  phase_t           step_size;

  assign step_size = half_q ? HALF_STEP : FULL_STEP;

  step_prescaler #(.DIV_W(DIV_W)) u_presc (
    .CLK      (CLK),
    .reset    (reset),
    .clear_i  (state_q == ST_IDLE),
    .enable_i (state_q == ST_MOVE),
    .period_i (div_q),
    .tick_o   (presc_tick)
  );

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    pos_d     = pos_q;
    rem_d     = rem_q;
    dir_d     = dir_q;
    half_d    = half_q;
    div_d     = div_q;
    step_tick = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          dir_d   = dir;
          rem_d   = steps;
          half_d  = half_step;
          div_d   = div;
          state_d = (steps != '0) ? ST_MOVE : ST_FINISH;
        end
      end
      ST_MOVE: begin
        // abort wins over a step falling due in the same cycle
        if (abort) begin
          state_d = ST_FINISH;
        end else if (presc_tick) begin
          step_tick = 1'b1;
          phase_d   = dir_q ? phase_q + step_size : phase_q - step_size;
          pos_d     = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
          rem_d     = rem_q - POS_W'(1);
          if (rem_q == POS_W'(1)) begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
`ifdef COIL_IDLE_OFF_EN
    coil_d = (state_d == ST_MOVE) ? COIL_TABLE[phase_d] : 4'b0000;
`else
    coil_d = COIL_TABLE[phase_d];
`endif
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      pos_q   <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      half_q  <= 1'b0;
      div_q   <= '0;
      coil_q  <= COIL_RESET;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pos_q   <= pos_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      half_q  <= half_d;
      div_q   <= div_d;
      coil_q  <= coil_d;
    end
  end

  assign busy     = (state_q == ST_MOVE);
  assign done     = (state_q == ST_FINISH);
  assign position = pos_q;
  assign coil     = coil_q;

endmodule

// File: tb/tb_stepper_ctrl.sv
// tb/tb_stepper_ctrl.sv - randomized self-checking bench for stepper_ctrl against a move-level model
module tb_stepper_ctrl;

  localparam int PW = 8;
  localparam int DW = 16;

  logic          CLK = 1'b0;
  logic          reset;
  logic          start, dir, half_step, abort;
  logic [PW-1:0] steps;
  logic [DW-1:0] div;
  logic          busy, done, step_tick;
  logic [PW-1:0] position;
  logic [3:0]    coil;

  int n_pass = 0;
  int n_total = 0;
  int m_phase = 0;
  int m_pos = 0;
  logic [3:0] tbl [8];

  stepper_ctrl #(.POS_W(PW), .DIV_W(DW)) dut (
    .CLK(CLK), .reset(reset), .start(start), .dir(dir), .steps(steps),
    .half_step(half_step), .div(div), .abort(abort), .busy(busy), .done(done),
    .step_tick(step_tick), .position(position), .coil(coil)
  );

  always #5 CLK = ~CLK;

  function automatic logic [3:0] exp_coil(input bit moving);
`ifdef COIL_IDLE_OFF_EN
    return moving ? tbl[m_phase] : 4'b0000;
`else
    return tbl[m_phase];
`endif
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(posedge CLK); #1;
    reset = 1'b0;
    m_phase = 0;
    m_pos = 0;
  endtask

  // Called just after a rising edge; abort_at = index of the tick whose cycle carries abort (0 = none).
  task automatic run_move(input string tag, input bit d, input int n, input bit h,
                          input int dv, input int abort_at, output int ticks);
    int c;
    bit moving, fin, ab, due, e_tick;
    logic [3:0] e_coil;
    ticks = 0;
    c = 0;
    start = 1'b1; dir = d; steps = PW'(n); half_step = h; div = DW'(dv); abort = 1'b0;
    @(posedge CLK); #1;
    moving = (n != 0);
    fin = (n == 0);
    while (moving || fin) begin
      c++;
      start = 1'($urandom); dir = 1'($urandom); steps = PW'($urandom);
      half_step = 1'($urandom); div = DW'($urandom_range(0, 3));
      ab = 1'b0; e_tick = 1'b0;
      if (moving) begin
        due = (c % (dv + 1)) == 0;
        if (due && abort_at == ticks + 1) ab = 1'b1;
        abort = ab;
        e_tick = due && !ab;
      end else begin
        abort = 1'($urandom);
      end
      e_coil = exp_coil(moving);
      @(negedge CLK);
      n_total++; if (busy !== moving) $display("FAIL %s c%0d busy got %b want %b", tag, c, busy, moving); else n_pass++;
      n_total++; if (done !== fin) $display("FAIL %s c%0d done got %b want %b", tag, c, done, fin); else n_pass++;
      n_total++; if (step_tick !== e_tick) $display("FAIL %s c%0d step_tick got %b want %b", tag, c, step_tick, e_tick); else n_pass++;
      n_total++; if (coil !== e_coil) $display("FAIL %s c%0d coil got %b want %b", tag, c, coil, e_coil); else n_pass++;
      n_total++; if (position !== PW'(m_pos)) $display("FAIL %s c%0d position got %0d want %0d", tag, c, position, m_pos); else n_pass++;
      if (e_tick) begin
        m_phase = (m_phase + (d ? (h ? 1 : 2) : (h ? 7 : 6))) % 8;
        m_pos = (m_pos + (d ? 1 : -1)) & ((1 << PW) - 1);
        ticks++;
      end
      if (fin) fin = 1'b0;
      else if (ab || ticks == n) begin moving = 1'b0; fin = 1'b1; end
      if (c > 4000) begin
        n_total++;
        $display("FAIL %s timeout got %0d ticks want move end", tag, ticks);
        moving = 1'b0; fin = 1'b0;
      end
      @(posedge CLK); #1;
    end
    start = 1'b0; abort = 1'b0;
    e_coil = exp_coil(1'b0);
    @(negedge CLK);
    n_total++; if (busy !== 1'b0 || done !== 1'b0 || step_tick !== 1'b0)
      $display("FAIL %s idle flags got %b%b%b want 000", tag, busy, done, step_tick); else n_pass++;
    n_total++; if (coil !== e_coil) $display("FAIL %s idle coil got %b want %b", tag, coil, e_coil); else n_pass++;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    logic [3:0] e_coil;
    reset = 1'b1; start = 0; dir = 0; steps = '0; half_step = 0; div = '0; abort = 0;
    m_phase = 0; m_pos = 0;
    e_coil = exp_coil(1'b0);
    #12;
    n_total++; if (busy !== 0 || done !== 0 || step_tick !== 0) $display("FAIL reset flags got %b%b%b want 000", busy, done, step_tick); else n_pass++;
    n_total++; if (position !== '0) $display("FAIL reset position got %0d want 0", position); else n_pass++;
    n_total++; if (coil !== e_coil) $display("FAIL reset coil got %b want %b", coil, e_coil); else n_pass++;
    @(posedge CLK); #1;
    reset = 1'b0;
  endtask

  task automatic test_full_fwd();
    int t;
    run_move("full_fwd", 1'b1, 4, 1'b0, 2, 0, t);
    n_total++; if (t != 4 || position !== PW'(4)) $display("FAIL full_fwd end got ticks %0d pos %0d want 4 4", t, position); else n_pass++;
  endtask

  task automatic test_half_rev();
    int t;
    do_reset();
    run_move("half_rev", 1'b0, 3, 1'b1, 0, 0, t);
    n_total++; if (position !== 8'hFD) $display("FAIL half_rev position got %h want fd", position); else n_pass++;
  endtask

  task automatic test_zero_steps();
    int t;
    run_move("zero", 1'($urandom), 0, 1'($urandom), $urandom_range(0, 5), 0, t);
    n_total++; if (t != 0) $display("FAIL zero ticks got %0d want 0", t); else n_pass++;
  endtask

  task automatic test_abort();
    int t;
    do_reset();
    run_move("abort", 1'b1, 10, 1'b0, 4, 3, t);
    n_total++; if (t != 2 || position !== PW'(2)) $display("FAIL abort end got ticks %0d pos %0d want 2 2", t, position); else n_pass++;
  endtask

  task automatic test_wrap();
    int t;
    do_reset();
    run_move("wrap_rev", 1'b0, 6, 1'b0, 0, 0, t);
    run_move("wrap_fwd", 1'b1, 9, 1'b0, 1, 0, t);
    n_total++; if (position !== PW'(3)) $display("FAIL wrap position got %0d want 3", position); else n_pass++;
  endtask

  task automatic test_reset_mid_move();
    logic [3:0] e_coil;
    start = 1'b1; dir = 1'b1; steps = PW'(20); half_step = 1'b0; div = DW'(1);
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (5) @(posedge CLK);
    #3;
    reset = 1'b1;
    m_phase = 0; m_pos = 0;
    e_coil = exp_coil(1'b0);
    #1;
    n_total++; if (busy !== 0 || done !== 0) $display("FAIL midreset flags got %b%b want 00", busy, done); else n_pass++;
    n_total++; if (position !== '0 || coil !== e_coil) $display("FAIL midreset pos/coil got %0d %b want 0 %b", position, coil, e_coil); else n_pass++;
    @(posedge CLK); #1;
    reset = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      n_total++; if (done !== 0 || busy !== 0) $display("FAIL midreset after got done %b busy %b want 0 0", done, busy); else n_pass++;
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_random();
    int t, n, ab_at;
    for (int i = 0; i < 25; i++) begin
      n = $urandom_range(0, 12);
      ab_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 12) : 0;
      run_move("random", 1'($urandom), n, 1'($urandom), $urandom_range(0, 3), ab_at, t);
    end
  endtask

  initial begin
    tbl = '{4'b1010, 4'b0010, 4'b0110, 4'b0100, 4'b0101, 4'b0001, 4'b1001, 4'b1000};
    test_reset();
    test_full_fwd();
    test_half_rev();
    test_zero_steps();
    test_abort();
    test_wrap();
    test_reset_mid_move();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
